mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; STARVE_MAX, default 4, maximum consecutive data grants while fetch waits.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports: if_req in 1, fetch request; if_addr in ADDR_W, fetch address; if_gnt out 1, fetch accepted this cycle.
REQ-005 SHALL have ports: if_rvalid out 1, fetch data valid; if_rdata out 32, fetch data.
REQ-006 SHALL have ports: d_req in 1, data request; d_we in 1, store (1) or load (0); d_addr in ADDR_W; d_wdata in 32; d_be in 4, byte enables.
REQ-007 SHALL have ports: d_gnt out 1, data accepted; d_rvalid out 1, load data valid; d_rdata out 32, load data.
REQ-008 SHALL have ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 32; mem_be out 4; mem_rdata in 32, valid one cycle after a read access.
REQ-009 SHALL have port: busy out 1, high while a read response is outstanding.

Function
REQ-010 SHALL issue at most one memory access per cycle; grant and access are combinational in the request cycle.
REQ-011 SHALL drive a fetch grant as mem_en=1, mem_we=0, mem_addr=if_addr, mem_be=4'hF.
REQ-012 SHALL drive a data grant as mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata, mem_be=d_be.
REQ-013 SHALL give d_req priority over if_req when both are high, subject to REQ-018.
REQ-014 SHALL record the read owner in a response register with states NONE, FETCH, DATA; the register is loaded every cycle from the current read grant, or NONE when there is none.
REQ-015 SHALL assert if_rvalid (owner FETCH) or d_rvalid (owner DATA) for exactly one cycle, the cycle after grant, with rdata = mem_rdata.
REQ-016 SHALL NOT produce an rvalid for stores; a store completes on d_gnt.
REQ-017 SHALL allow back-to-back grants every cycle, with no bubble between response and next grant.
REQ-018 SHALL, when MEM_ARB_STARVE_EN is defined, count consecutive d_gnt cycles with if_req high and saturate the count at STARVE_MAX.
REQ-019 SHALL grant fetch over data on the cycle the count equals STARVE_MAX.
REQ-020 SHALL clear the count on any if_gnt, or on any cycle with if_req low.
REQ-021 SHALL drive mem_en=0 and all grants 0 when no request is present; mem_addr, mem_wdata and mem_be are then don't-care but SHALL be 0.
REQ-022 SHALL make if_rdata and d_rdata track mem_rdata; they are only meaningful when the matching rvalid is high.

Reset
REQ-023 SHALL, while reset=0, force response owner NONE, starvation count 0, all gnt/rvalid/mem_en/busy outputs 0.
REQ-024 SHALL discard a response outstanding at reset; no rvalid appears in the cycle after reset is released.

Configuration
REQ-025 SHALL use macro MEM_ARB_STARVE_EN: defined, REQ-018..REQ-020 apply; undefined, data always wins and no counter logic exists.

Structure
REQ-026 SHALL place in package mem_arb_pkg: the owner enum (NONE/FETCH/DATA) and the default STARVE_MAX.
REQ-027 SHALL implement the starvation counter as sub-module arb_starve_cnt, instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-028 SHALL cover fetch-only: if_req=1, if_addr=0x0 to 0x1C over 8 cycles -> if_gnt each cycle, if_rvalid each following cycle with the ROM words in order.
REQ-029 SHALL cover a collision load: if_req=1 and d_req=1, d_we=0, d_addr=0x100 -> d_gnt=1, if_gnt=0, next cycle d_rvalid=1 and if_rvalid=0.
REQ-030 SHALL cover a store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'hF -> mem_we=1 that cycle, no d_rvalid, and a later load returns 0xDEADBEEF.
REQ-031 SHALL cover starvation with MEM_ARB_STARVE_EN and STARVE_MAX=4: if_req and d_req both held high -> 4 d_gnt, 1 if_gnt, repeating; without the macro -> d_gnt continuously.
REQ-032 SHALL cover reset mid-read: reset=0 in the cycle after a load grant -> d_rvalid=0, busy=0, and no rvalid after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );
endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive data grants taken while a fetch is waiting; flags when fetch must win.
module arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic starve
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!if_req || if_gnt) begin
            cnt <= '0;
        end else if (d_gnt && (cnt != CW'(STARVE_MAX))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign starve = (cnt == CW'(STARVE_MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter; data wins unless MEM_ARB_STARVE_EN
// is defined, in which case a fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

    logic              fetch_pri;
    logic              d_win;
    logic              f_win;
    logic [ADDR_W-1:0] addr_mux;
    logic [31:0]       wdata_mux;
    logic [3:0]        be_mux;
    logic              we_mux;
    owner_e            owner;
    owner_e            owner_nxt;

`ifdef MEM_ARB_STARVE_EN
    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .if_req (bus.if_req),
        .if_gnt (f_win),
        .d_gnt  (d_win),
        .starve (fetch_pri)
    );
`else
    assign fetch_pri = 1'b0;
`endif

    always_comb begin
        d_win     = reset && bus.d_req && !(fetch_pri && bus.if_req);
        f_win     = reset && bus.if_req && !d_win;
        addr_mux  = '0;
        wdata_mux = '0;
        be_mux    = '0;
        we_mux    = 1'b0;
        owner_nxt = NONE;
        if (d_win) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            be_mux    = bus.d_be;
            we_mux    = bus.d_we;
            owner_nxt = bus.d_we ? NONE : DATA;
        end else if (f_win) begin
            addr_mux  = bus.if_addr;
            be_mux    = '1;
            owner_nxt = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner <= NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    assign bus.if_gnt    = f_win;
    assign bus.d_gnt     = d_win;
    assign bus.mem_en    = d_win || f_win;
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_be    = be_mux;

    // Response flags are masked by reset so nothing leaks out while it is held.
    assign bus.if_rvalid = reset && (owner == FETCH);
    assign bus.d_rvalid  = reset && (owner == DATA);
    assign bus.busy      = reset && (owner != NONE);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;
    localparam int unsigned SMAX = 4;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W    (32),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] env_mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    // Memory environment: registered read port, byte-enabled writes.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) env_mem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= env_mem[bus.mem_addr[11:2]];
            end
        end
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          exp_owner = 0;
    logic [31:0] exp_rdata = '0;
    int unsigned starve_cnt = 0;
    int unsigned if_gnt_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst_n, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe);
        logic dwin, fwin;
        reset         = rst_n;
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.d_req     = dr;
        bus.d_we      = dw;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        bus.d_be      = dbe;
        @(negedge clk);
        dwin = rst_n && dr && !(STARVE_ON && ir && (starve_cnt >= SMAX));
        fwin = rst_n && ir && !dwin;
        check("if_gnt", bus.if_gnt, fwin);
        check("d_gnt", bus.d_gnt, dwin);
        check("mem_en", bus.mem_en, dwin || fwin);
        check("mem_we", bus.mem_we, dwin && dw);
        check("mem_addr", bus.mem_addr, dwin ? da : (fwin ? ia : 32'h0));
        check("mem_be", bus.mem_be, dwin ? dbe : (fwin ? 4'hF : 4'h0));
        if (!fwin) check("mem_wdata", bus.mem_wdata, dwin ? dwd : 32'h0);
        check("if_rvalid", bus.if_rvalid, rst_n && exp_owner == 1);
        check("d_rvalid", bus.d_rvalid, rst_n && exp_owner == 2);
        check("busy", bus.busy, rst_n && exp_owner != 0);
        if (rst_n && exp_owner == 1) check("if_rdata", bus.if_rdata, exp_rdata);
        if (rst_n && exp_owner == 2) check("d_rdata", bus.d_rdata, exp_rdata);
        if_gnt_seen += 32'(bus.if_gnt);
        if (!rst_n) begin
            exp_owner  = 0;
            starve_cnt = 0;
        end else begin
            if (dwin && dw)
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) ref_mem[da[11:2]][8*b +: 8] = dwd[8*b +: 8];
            if (dwin && !dw) begin
                exp_owner = 2;
                exp_rdata = ref_mem[da[11:2]];
            end else if (fwin) begin
                exp_owner = 1;
                exp_rdata = ref_mem[ia[11:2]];
            end else begin
                exp_owner = 0;
            end
            if (!ir || fwin) starve_cnt = 0;
            else if (dwin) starve_cnt = (starve_cnt + 1 > SMAX) ? SMAX : starve_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
            ref_mem[i] = env_mem[i];
        end
        bus.mem_rdata = '0;

        repeat (3) step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, '0, 4'hF);
        idle();

        // Fetch-only stream over the first eight ROM words.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0, '0, '0, '0);
        idle();

        // Collision load, then store and read-back.
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        idle();
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        idle();
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        check("store_readback", bus.d_rdata, 32'hDEADBEEF);

        // Both requesters held high: fetch only gets through with the starvation guard.
        idle();
        if_gnt_seen = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'(32'h200 + i * 4), '0, 4'hF);
        check("starve_if_gnts", if_gnt_seen, STARVE_ON ? 32'd2 : 32'd0);
        idle();

        // Reset lands in the cycle after a load grant.
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h104, '0, 4'hF);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        idle();
        idle();

        for (int n = 0; n < 500; n++) begin
            ra = 32'($urandom_range(0, 1023)) << 2;
            rb = 32'($urandom_range(0, 1023)) << 2;
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), ra,
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, rb,
                 $urandom, 4'($urandom_range(0, 15)));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
